// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store/copy memory initiator.
// The op codes are also used by the CPU memory stage.
package mem_access_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_WAIT = 3'd2,
        S_ST_WR   = 3'd3,
        S_CP_RD   = 3'd4,
        S_CP_WAIT = 3'd5,
        S_CP_WR   = 3'd6,
        S_RESP    = 3'd7
    } state_t;

endpackage

// File: rtl/mem_access_if.sv
// Request/response channels plus the data_memory port of the memory access unit.
// The slave modport is the unit; the master modport is the CPU stage and memory side.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_dst;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_dst, req_len, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_write, mem_read, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_dst, req_len, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store/copy initiator in front of data_memory. Every output is a register
// loaded from the next-state logic, so strobes line up with the FSM state they belong to.
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = mem_access_pkg::ADDR_W,
    parameter int DATA_W = mem_access_pkg::DATA_W,
    parameter int LEN_W  = mem_access_pkg::LEN_W
) (
    input  logic        clock,
    input  logic        reset_n,
    mem_access_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_src, w_src;
    logic [ADDR_W-1:0] r_dst, w_dst;
    logic [LEN_W-1:0]  r_rem, w_rem;
    logic [LEN_W-1:0]  r_len, w_len;
    logic              r_req_ready, w_req_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              r_mem_write, w_mem_write;
    logic              r_mem_read, w_mem_read;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, next datapath values and next output values
    always_comb begin
        w_next      = r_state;
        w_src       = r_src;
        w_dst       = r_dst;
        w_rem       = r_rem;
        w_len       = r_len;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_src = bus.req_addr;
                    w_dst = bus.req_dst;
                    w_rem = bus.req_len;
                    w_len = bus.req_len;
                    case (bus.req_op)
                        OP_LOAD: begin
                            w_next     = S_LD_RD;
                            w_mem_read = 1'b1;
                            w_mem_addr = bus.req_addr;
                        end
                        OP_STORE: begin
                            w_next      = S_ST_WR;
                            w_mem_write = 1'b1;
                            w_mem_addr  = bus.req_addr;
                            w_mem_wdata = bus.req_wdata;
                        end
                        OP_COPY: begin
                            if (bus.req_len != LEN_ZERO) begin
                                w_next     = S_CP_RD;
                                w_mem_read = 1'b1;
                                w_mem_addr = bus.req_addr;
                            end else begin
                                w_next      = S_RESP;
                                w_rsp_valid = 1'b1;
                                w_rsp_rdata = DATA_ZERO;
                                w_rsp_err   = 1'b0;
                            end
                        end
                        default: begin
                            w_next      = S_RESP;
                            w_rsp_valid = 1'b1;
                            w_rsp_rdata = DATA_ZERO;
                            w_rsp_err   = 1'b1;
                        end
                    endcase
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LD_RD: begin
                w_next = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                w_next      = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = bus.mem_rdata;
                w_rsp_err   = 1'b0;
            end
            S_ST_WR: begin
                w_next      = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = DATA_ZERO;
                w_rsp_err   = 1'b0;
            end
            S_CP_RD: begin
                w_next = S_CP_WAIT;
            end
            S_CP_WAIT: begin
                w_next      = S_CP_WR;
                w_mem_write = 1'b1;
                w_mem_addr  = r_dst;
                w_mem_wdata = bus.mem_rdata;
            end
            S_CP_WR: begin
                // Pointers wrap naturally at 2^ADDR_W; overlapping ranges are not detected.
                w_src = r_src + ADDR_ONE;
                w_dst = r_dst + ADDR_ONE;
                w_rem = r_rem - LEN_ONE;
                if (r_rem != LEN_ONE) begin
                    w_next     = S_CP_RD;
                    w_mem_read = 1'b1;
                    w_mem_addr = r_src + ADDR_ONE;
                end else begin
                    w_next      = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = {{(DATA_W-LEN_W){1'b0}}, r_len};
                    w_rsp_err   = 1'b0;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next      = S_IDLE;
                    w_rsp_valid = 1'b0;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_req_ready = (w_next == S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_src       <= {ADDR_W{1'b0}};
            r_dst       <= {ADDR_W{1'b0}};
            r_rem       <= LEN_ZERO;
            r_len       <= LEN_ZERO;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= DATA_ZERO;
            r_rsp_err   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= DATA_ZERO;
        end else begin
            r_src       <= w_src;
            r_dst       <= w_dst;
            r_rem       <= w_rem;
            r_len       <= w_len;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_mem_write <= w_mem_write;
            r_mem_read  <= w_mem_read;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural data_memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   rd_cnt  = 0;
    int   wr_cnt  = 0;
    logic [31:0] rd_log    [0:15];
    logic [31:0] mem_model [0:63];

    mem_access_if bus ();

    mem_access_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // data_memory model: synchronous write, one-cycle registered read
    always @(posedge clock) begin
        if (bus.mem_write) begin
            mem_model[bus.mem_addr[5:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_read) begin
            bus.mem_rdata <= mem_model[bus.mem_addr[5:0]];
            rd_log[rd_cnt[3:0]] <= bus.mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] dst,
                        input logic [7:0] len, input logic [31:0] wdata);
        int t = 0;
        while (!bus.req_ready && t < 50) begin
            step();
            t++;
        end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_dst   = dst;
        bus.req_len   = len;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_cyc);
        int cyc = 1;
        while (!bus.rsp_valid && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("hs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic xact(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] dst, input logic [7:0] len, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        send(op, addr, dst, len, wdata);
        wait_rsp(tag, exp_lat);
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        handshake();
    endtask

    initial begin
        int r0;
        int w0;
        logic [3:0] idx;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 32'd0;
        bus.req_dst   = 32'd0;
        bus.req_len   = 8'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        #4 reset_n = 1'b1;
        step();

        // STORE 500 to 10
        w0 = wr_cnt;
        send(OP_STORE, 32'd10, 32'd0, 8'd0, 32'd500);
        chk("st_mem_write", 32'(bus.mem_write), 32'd1);
        chk("st_mem_read", 32'(bus.mem_read), 32'd0);
        chk("st_mem_addr", bus.mem_addr, 32'd10);
        chk("st_mem_wdata", bus.mem_wdata, 32'd500);
        wait_rsp("st", 2);
        chk("st_rdata", bus.rsp_rdata, 32'd0);
        chk("st_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        handshake();

        // LOAD 10
        send(OP_LOAD, 32'd10, 32'd0, 8'd0, 32'd0);
        chk("ld_mem_read", 32'(bus.mem_read), 32'd1);
        chk("ld_mem_write", 32'(bus.mem_write), 32'd0);
        chk("ld_mem_addr", bus.mem_addr, 32'd10);
        wait_rsp("ld", 3);
        chk("ld_rdata", bus.rsp_rdata, 32'd500);
        handshake();

        // COPY 10..12 -> 20..22
        xact("pre10", OP_STORE, 32'd10, 32'd0, 8'd0, 32'd7, 2, 32'd0, 1'b0);
        xact("pre11", OP_STORE, 32'd11, 32'd0, 8'd0, 32'd8, 2, 32'd0, 1'b0);
        xact("pre12", OP_STORE, 32'd12, 32'd0, 8'd0, 32'd9, 2, 32'd0, 1'b0);
        r0 = rd_cnt;
        w0 = wr_cnt;
        xact("cp3", OP_COPY, 32'd10, 32'd20, 8'd3, 32'd0, 10, 32'd3, 1'b0);
        chk("cp3_reads", 32'(rd_cnt - r0), 32'd3);
        chk("cp3_writes", 32'(wr_cnt - w0), 32'd3);
        xact("cp3_d20", OP_LOAD, 32'd20, 32'd0, 8'd0, 32'd0, 3, 32'd7, 1'b0);
        xact("cp3_d21", OP_LOAD, 32'd21, 32'd0, 8'd0, 32'd0, 3, 32'd8, 1'b0);
        xact("cp3_d22", OP_LOAD, 32'd22, 32'd0, 8'd0, 32'd0, 3, 32'd9, 1'b0);

        // COPY len 0 and reserved op
        r0 = rd_cnt;
        w0 = wr_cnt;
        xact("cp0", OP_COPY, 32'd30, 32'd40, 8'd0, 32'd0, 1, 32'd0, 1'b0);
        xact("rsvd", OP_RSVD, 32'd10, 32'd20, 8'd3, 32'd0, 1, 32'd0, 1'b1);
        chk("cp0_rsvd_reads", 32'(rd_cnt - r0), 32'd0);
        chk("cp0_rsvd_writes", 32'(wr_cnt - w0), 32'd0);

        // Response backpressure with a pending request
        send(OP_LOAD, 32'd10, 32'd0, 8'd0, 32'd0);
        wait_rsp("bp", 3);
        bus.req_op    = OP_STORE;
        bus.req_addr  = 32'd33;
        bus.req_wdata = 32'd1234;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'd7);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("bp_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_hs_no_write", 32'(bus.mem_write), 32'd0);
        step();
        bus.req_valid = 1'b0;
        chk("bp_st_write", 32'(bus.mem_write), 32'd1);
        chk("bp_st_addr", bus.mem_addr, 32'd33);
        chk("bp_st_wdata", bus.mem_wdata, 32'd1234);
        wait_rsp("bp_st", 2);
        handshake();

        // Address wrap
        xact("pre_ff", OP_STORE, 32'hFFFF_FFFF, 32'd0, 8'd0, 32'd11, 2, 32'd0, 1'b0);
        xact("pre_00", OP_STORE, 32'd0, 32'd0, 8'd0, 32'd22, 2, 32'd0, 1'b0);
        r0 = rd_cnt;
        xact("wrap", OP_COPY, 32'hFFFF_FFFF, 32'd44, 8'd2, 32'd0, 7, 32'd2, 1'b0);
        idx = 4'(r0);
        chk("wrap_rd0_addr", rd_log[idx], 32'hFFFF_FFFF);
        idx = 4'(r0 + 1);
        chk("wrap_rd1_addr", rd_log[idx], 32'd0);
        xact("wrap_d44", OP_LOAD, 32'd44, 32'd0, 8'd0, 32'd0, 3, 32'd11, 1'b0);
        xact("wrap_d45", OP_LOAD, 32'd45, 32'd0, 8'd0, 32'd0, 3, 32'd22, 1'b0);

        // Reset during the second CP_WR of a 4-word copy
        xact("pre50", OP_STORE, 32'd50, 32'd0, 8'd0, 32'd101, 2, 32'd0, 1'b0);
        xact("pre51", OP_STORE, 32'd51, 32'd0, 8'd0, 32'd102, 2, 32'd0, 1'b0);
        xact("pre57", OP_STORE, 32'd57, 32'd0, 8'd0, 32'h0000_DEAD, 2, 32'd0, 1'b0);
        send(OP_COPY, 32'd50, 32'd56, 8'd4, 32'd0);
        repeat (5) step();
        chk("mid_cp_write", 32'(bus.mem_write), 32'd1);
        chk("mid_cp_addr", bus.mem_addr, 32'd57);
        chk("mid_cp_wdata", bus.mem_wdata, 32'd102);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("arst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        step();
        step();
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        xact("post_d56", OP_LOAD, 32'd56, 32'd0, 8'd0, 32'd0, 3, 32'd101, 1'b0);
        xact("post_d57", OP_LOAD, 32'd57, 32'd0, 8'd0, 32'd0, 3, 32'h0000_DEAD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
